// File: rtl/imem_arb_pkg.sv
// Shared types for the instruction-memory arbiter: owner tags, FSM states
// and the supported memory-latency ceiling.
package imem_arb_pkg;

   typedef enum logic {
      OWN_F = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   typedef enum logic {
      PRI_F   = 1'b0,
      BOOST_D = 1'b1
   } arb_state_t;

   localparam int MAX_MEM_LAT = 4;

endpackage

// File: rtl/imem_arb_tag_pipe.sv
// Tracks each in-flight instr_mem read as a {valid, owner} tag, delayed by
// MEM_LAT cycles so the tag emerges in the cycle the read data does.
import imem_arb_pkg::*;

module imem_arb_tag_pipe #(
   parameter int MEM_LAT = 1
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   i_vld,
   input  owner_t i_own,
   output logic   o_vld,
   output owner_t o_own
);

   if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : g_bad_lat
      $error("imem_arb_tag_pipe: MEM_LAT out of range");
   end

   logic [MEM_LAT-1:0] r_vld;
   logic [MEM_LAT-1:0] r_own;

   // shift a new tag in every cycle; reset drops all in-flight reads
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_vld <= '0;
         r_own <= '0;
      end else begin
         r_vld[0] <= i_vld;
         r_own[0] <= i_own;
         for (int i = 1; i < MEM_LAT; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_own[i] <= r_own[i-1];
         end
      end
   end

   assign o_vld = r_vld[MEM_LAT-1];
   assign o_own = owner_t'(r_own[MEM_LAT-1]);

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter for the synchronous-read instruction memory.
// Fetch (F) has priority; the debug reader (D) is guaranteed a grant after
// STARVE_LIMIT consecutive denied cycles. Read data returns with a per-port
// valid pulse MEM_LAT cycles after the grant.
// Optional build macro IMEM_ARB_STATS_EN adds grant/stall counters.
import imem_arb_pkg::*;

module imem_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 1,
   parameter int STARVE_LIMIT = 7
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
`ifdef IMEM_ARB_STATS_EN
   output logic [15:0]       f_grant_cnt,
   output logic [15:0]       d_grant_cnt,
   output logic [15:0]       d_stall_cnt,
`endif
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [7:0] LIM = 8'(STARVE_LIMIT);

   arb_state_t        r_state, w_state_nxt;
   logic [7:0]        r_cnt, w_cnt_nxt;
   logic              w_f_gnt, w_d_gnt;
   logic [ADDR_W-1:0] w_gnt_addr;
   logic              w_tp_vld;
   owner_t            w_tp_own;
   logic              w_f_rvalid, w_d_rvalid;
   logic [DATA_W-1:0] r_f_rdata, r_d_rdata;

   // state register and starvation counter
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= PRI_F;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // grant decode; nothing is granted while reset is held
   always_comb begin
      w_f_gnt = 1'b0;
      w_d_gnt = 1'b0;
      if (reset_n) begin
         case (r_state)
            PRI_F: begin
               if (f_req)      w_f_gnt = 1'b1;
               else if (d_req) w_d_gnt = 1'b1;
            end
            BOOST_D: begin
               if (d_req)      w_d_gnt = 1'b1;
               else if (f_req) w_f_gnt = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // count consecutive denied D cycles, saturating at the limit
   always_comb begin
      w_cnt_nxt = '0;
      if (d_req && !w_d_gnt)
         w_cnt_nxt = (r_cnt == LIM) ? LIM : r_cnt + 8'd1;
   end

   // boost D in the cycle after its denial streak reaches the limit
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         PRI_F:   if (w_cnt_nxt == LIM) w_state_nxt = BOOST_D;
         BOOST_D: w_state_nxt = PRI_F;
         default: w_state_nxt = PRI_F;
      endcase
   end

   assign f_gnt      = w_f_gnt;
   assign d_gnt      = w_d_gnt;
   assign mem_en     = w_f_gnt | w_d_gnt;
   assign w_gnt_addr = w_d_gnt ? d_addr : (w_f_gnt ? f_addr : '0);
   assign mem_addr   = {w_gnt_addr[ADDR_W-1:2], 2'b00};

   imem_arb_tag_pipe #(.MEM_LAT(MEM_LAT)) u_tag_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .i_vld   (mem_en),
      .i_own   (w_d_gnt ? OWN_D : OWN_F),
      .o_vld   (w_tp_vld),
      .o_own   (w_tp_own)
   );

   // rvalid is masked during reset so a read issued just before reset never surfaces
   assign w_f_rvalid = reset_n & w_tp_vld & (w_tp_own == OWN_F);
   assign w_d_rvalid = reset_n & w_tp_vld & (w_tp_own == OWN_D);

   // capture returned words so each port keeps showing its last read between pulses
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_f_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_f_rvalid) r_f_rdata <= mem_rdata;
         if (w_d_rvalid) r_d_rdata <= mem_rdata;
      end
   end

   // in the valid cycle the word comes straight from memory, otherwise from the hold register
   assign f_rvalid = w_f_rvalid;
   assign d_rvalid = w_d_rvalid;
   assign f_rdata  = w_f_rvalid ? mem_rdata : r_f_rdata;
   assign d_rdata  = w_d_rvalid ? mem_rdata : r_d_rdata;

`ifdef IMEM_ARB_STATS_EN
   logic [15:0] r_f_grant_cnt, r_d_grant_cnt, r_d_stall_cnt;

   // free-running wrap-around activity counters
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_f_grant_cnt <= '0;
         r_d_grant_cnt <= '0;
         r_d_stall_cnt <= '0;
      end else begin
         if (w_f_gnt)           r_f_grant_cnt <= r_f_grant_cnt + 16'd1;
         if (w_d_gnt)           r_d_grant_cnt <= r_d_grant_cnt + 16'd1;
         if (d_req && !w_d_gnt) r_d_stall_cnt <= r_d_stall_cnt + 16'd1;
      end
   end

   assign f_grant_cnt = r_f_grant_cnt;
   assign d_grant_cnt = r_d_grant_cnt;
   assign d_stall_cnt = r_d_stall_cnt;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: a MEM_LAT=1 instance and a MEM_LAT=3
// instance, each with its own instr_mem model returning 0xA5000000|addr.
module tb_imem_arbiter;

   logic        clk, reset_n;
   // MEM_LAT=1 instance
   logic        f_req, d_req, f_gnt, d_gnt, f_rvalid, d_rvalid, mem_en;
   logic [31:0] f_addr, d_addr, f_rdata, d_rdata, mem_addr, mem_rdata;
   // MEM_LAT=3 instance
   logic        f3_req, d3_req, f3_gnt, d3_gnt, f3_rvalid, d3_rvalid, mem3_en;
   logic [31:0] f3_addr, d3_addr, f3_rdata, d3_rdata, mem3_addr, mem3_rdata;
   logic [31:0] p1, p2;
`ifdef IMEM_ARB_STATS_EN
   logic [15:0] f_gcnt, d_gcnt, d_scnt, f3_gcnt, d3_gcnt, d3_scnt;
`endif

   int total = 0;
   int bad   = 0;

   imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(7)) dut (
      .clk(clk), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef IMEM_ARB_STATS_EN
      .f_grant_cnt(f_gcnt), .d_grant_cnt(d_gcnt), .d_stall_cnt(d_scnt),
`endif
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(7)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .f_req(f3_req), .f_addr(f3_addr), .f_gnt(f3_gnt), .f_rvalid(f3_rvalid), .f_rdata(f3_rdata),
      .d_req(d3_req), .d_addr(d3_addr), .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
`ifdef IMEM_ARB_STATS_EN
      .f_grant_cnt(f3_gcnt), .d_grant_cnt(d3_gcnt), .d_stall_cnt(d3_scnt),
`endif
      .mem_en(mem3_en), .mem_addr(mem3_addr), .mem_rdata(mem3_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory models: junk on idle cycles so misaligned data capture shows up
   always @(posedge clk) mem_rdata <= mem_en ? (32'hA500_0000 | mem_addr) : 32'hDEAD_BEEF;
   always @(posedge clk) begin
      p1         <= mem3_en ? (32'hA500_0000 | mem3_addr) : 32'hDEAD_BEEF;
      p2         <= p1;
      mem3_rdata <= p2;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      f_req = 1'b1; d_req = 1'b1; f_addr = 32'h20; d_addr = 32'h40;
      f3_req = 1'b0; d3_req = 1'b0; f3_addr = 32'h0; d3_addr = 32'h0;
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (f_gnt !== 1'b0)    begin bad++; $display("FAIL rst_f_gnt: got %0b want 0", f_gnt); end
         total++; if (d_gnt !== 1'b0)    begin bad++; $display("FAIL rst_d_gnt: got %0b want 0", d_gnt); end
         total++; if (mem_en !== 1'b0)   begin bad++; $display("FAIL rst_mem_en: got %0b want 0", mem_en); end
         total++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0)
            begin bad++; $display("FAIL rst_rvalid: got %0b/%0b want 0/0", f_rvalid, d_rvalid); end
         total++; if (f_rdata !== 32'h0) begin bad++; $display("FAIL rst_f_rdata: got %0h want 0", f_rdata); end
         tick();
      end
      reset_n = 1'b1;
      #1;
      total++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0)
         begin bad++; $display("FAIL rel_first_gnt: got f=%0b d=%0b want f=1 d=0", f_gnt, d_gnt); end
      total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL rel_mem_addr: got %0h want 20", mem_addr); end
      tick();
      f_req = 1'b0; d_req = 1'b0;
      #1;
      total++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hA500_0020)
         begin bad++; $display("FAIL rel_rdata: got v=%0b %0h want v=1 a5000020", f_rvalid, f_rdata); end
      tick();
   endtask

   task automatic test_f_only();
      logic [31:0] addr [3];
      logic [31:0] dat  [3];
      addr = '{32'h10, 32'h14, 32'h18};
      dat  = '{32'hA500_0010, 32'hA500_0014, 32'hA500_0018};
      for (int i = 0; i < 5; i++) begin
         f_req = (i < 3);
         if (i < 3) f_addr = addr[i];
         #1;
         total++; if (f_gnt !== (i < 3)) begin bad++; $display("FAIL fonly_gnt[%0d]: got %0b want %0b", i, f_gnt, i < 3); end
         total++; if (d_gnt !== 1'b0)    begin bad++; $display("FAIL fonly_dgnt[%0d]: got %0b want 0", i, d_gnt); end
         if (i < 3) begin
            total++; if (mem_addr !== addr[i])
               begin bad++; $display("FAIL fonly_addr[%0d]: got %0h want %0h", i, mem_addr, addr[i]); end
         end else begin
            total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL fonly_idle_en[%0d]: got %0b want 0", i, mem_en); end
         end
         total++; if (f_rvalid !== (i >= 1 && i <= 3))
            begin bad++; $display("FAIL fonly_rvalid[%0d]: got %0b want %0b", i, f_rvalid, (i >= 1 && i <= 3)); end
         if (i >= 1 && i <= 3) begin
            total++; if (f_rdata !== dat[i-1])
               begin bad++; $display("FAIL fonly_rdata[%0d]: got %0h want %0h", i, f_rdata, dat[i-1]); end
         end
         if (i == 4) begin
            total++; if (f_rdata !== 32'hA500_0018)
               begin bad++; $display("FAIL fonly_hold: got %0h want a5000018", f_rdata); end
         end
         tick();
      end
   endtask

   task automatic test_starvation();
      f_req = 1'b1; d_req = 1'b1; f_addr = 32'h100; d_addr = 32'h204;
      for (int i = 0; i < 24; i++) begin
         #1;
         total++; if (d_gnt !== (i % 8 == 7))
            begin bad++; $display("FAIL starve_dgnt[%0d]: got %0b want %0b", i, d_gnt, i % 8 == 7); end
         total++; if (f_gnt !== (i % 8 != 7))
            begin bad++; $display("FAIL starve_fgnt[%0d]: got %0b want %0b", i, f_gnt, i % 8 != 7); end
         total++; if (d_rvalid !== (i > 0 && i % 8 == 0))
            begin bad++; $display("FAIL starve_drvalid[%0d]: got %0b want %0b", i, d_rvalid, i > 0 && i % 8 == 0); end
         if (i > 0 && i % 8 == 0) begin
            total++; if (d_rdata !== 32'hA500_0204)
               begin bad++; $display("FAIL starve_drdata[%0d]: got %0h want a5000204", i, d_rdata); end
         end
         tick();
      end
      f_req = 1'b0; d_req = 1'b0;
      #1;
      total++; if (d_rvalid !== 1'b1) begin bad++; $display("FAIL starve_last_drvalid: got %0b want 1", d_rvalid); end
      tick();
   endtask

   task automatic test_align_lat3();
      d_req = 1'b1; d_addr = 32'h13;
      #1;
      total++; if (d_gnt !== 1'b1 || mem_addr !== 32'h10)
         begin bad++; $display("FAIL align_addr: got gnt=%0b %0h want gnt=1 10", d_gnt, mem_addr); end
      tick();
      d_req = 1'b0;
      #1;
      total++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hA500_0010)
         begin bad++; $display("FAIL align_rdata: got v=%0b %0h want v=1 a5000010", d_rvalid, d_rdata); end
      tick();
      for (int i = 0; i < 7; i++) begin
         f3_req  = (i == 0 || i == 2);
         d3_req  = (i == 1);
         f3_addr = (i == 0) ? 32'h40 : 32'h60;
         d3_addr = 32'h51;
         #1;
         total++; if (f3_gnt !== f3_req || d3_gnt !== d3_req)
            begin bad++; $display("FAIL lat3_gnt[%0d]: got f=%0b d=%0b want f=%0b d=%0b", i, f3_gnt, d3_gnt, f3_req, d3_req); end
         if (i == 1) begin
            total++; if (mem3_addr !== 32'h50) begin bad++; $display("FAIL lat3_daddr: got %0h want 50", mem3_addr); end
         end
         total++; if (f3_rvalid !== (i == 3 || i == 5))
            begin bad++; $display("FAIL lat3_frvalid[%0d]: got %0b want %0b", i, f3_rvalid, i == 3 || i == 5); end
         total++; if (d3_rvalid !== (i == 4))
            begin bad++; $display("FAIL lat3_drvalid[%0d]: got %0b want %0b", i, d3_rvalid, i == 4); end
         if (i == 3) begin
            total++; if (f3_rdata !== 32'hA500_0040) begin bad++; $display("FAIL lat3_fdata0: got %0h want a5000040", f3_rdata); end
         end
         if (i == 4) begin
            total++; if (d3_rdata !== 32'hA500_0050) begin bad++; $display("FAIL lat3_ddata: got %0h want a5000050", d3_rdata); end
         end
         if (i == 5) begin
            total++; if (f3_rdata !== 32'hA500_0060) begin bad++; $display("FAIL lat3_fdata1: got %0h want a5000060", f3_rdata); end
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      d_req = 1'b1; d_addr = 32'h30; d3_req = 1'b1; d3_addr = 32'h34;
      #1;
      total++; if (d_gnt !== 1'b1 || d3_gnt !== 1'b1)
         begin bad++; $display("FAIL rmid_gnt: got %0b/%0b want 1/1", d_gnt, d3_gnt); end
      tick();
      d_req = 1'b0; d3_req = 1'b0; reset_n = 1'b0;
      #1;
      total++; if (d_rvalid !== 1'b0) begin bad++; $display("FAIL rmid_in_reset: got %0b want 0", d_rvalid); end
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         total++; if (d_rvalid !== 1'b0 || d3_rvalid !== 1'b0)
            begin bad++; $display("FAIL rmid_after[%0d]: got %0b/%0b want 0/0", k, d_rvalid, d3_rvalid); end
         tick();
      end
      total++; if (d_rdata !== 32'h0) begin bad++; $display("FAIL rmid_rdata: got %0h want 0", d_rdata); end
   endtask

`ifdef IMEM_ARB_STATS_EN
   task automatic test_stats();
      f_req = 1'b1; d_req = 1'b1; f_addr = 32'h100; d_addr = 32'h200;
      for (int i = 0; i < 16; i++) tick();
      f_req = 1'b0; d_req = 1'b0;
      #1;
      total++; if (f_gcnt !== 16'd14) begin bad++; $display("FAIL stats_f: got %0d want 14", f_gcnt); end
      total++; if (d_gcnt !== 16'd2)  begin bad++; $display("FAIL stats_d: got %0d want 2", d_gcnt); end
      total++; if (d_scnt !== 16'd14) begin bad++; $display("FAIL stats_stall: got %0d want 14", d_scnt); end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_f_only();
      test_starvation();
      test_align_lat3();
      test_reset_mid();
`ifdef IMEM_ARB_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
